// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode/state types and helpers shared by the multicycle ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULHU = 4'd11,
    ALU_DIVU  = 4'd12,
    ALU_REMU  = 4'd13
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic logic is_div(input alu_op_t op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
// ============================================================================
// alu_seq_muldiv : iterative unsigned shift-add multiplier / restoring divider
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0]   r_opb;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_div;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;

  // Multiply: {hi,lo} starts as {0,multiplier} and shifts right one bit per step.
  // Divide: {rem,quot} starts as {0,dividend}; w_diff[XLEN] set means the trial subtract borrowed.
  always_comb begin
    w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
    w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
    w_diff   = w_rem_sh - {1'b0, r_opb};
    w_acc_nxt = r_acc;
    if (r_div) begin
      if (!w_diff[XLEN]) w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      else               w_acc_nxt = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end else if (r_acc[0]) begin
      w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
    end else begin
      w_acc_nxt = {1'b0, r_acc[2*XLEN-1:1]};
    end
  end

  // done marks the cycle in which the final step is taken; hi/lo show its outcome.
  assign done = (r_cnt == CNT_W'(1));
  assign hi   = w_acc_nxt[2*XLEN-1:XLEN];
  assign lo   = w_acc_nxt[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_opb <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (start) begin
      r_acc <= {{XLEN{1'b0}}, a};
      r_opb <= b;
      r_cnt <= CNT_W'(XLEN);
      r_div <= div;
    end else if (r_cnt != '0) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_multicycle.sv
// ============================================================================
// alu_multicycle : valid/ready ALU, 1-cycle integer ops, XLEN-cycle mul/div
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            div_by_zero
);

  localparam int SHW = $clog2(XLEN);

  state_t          r_state;
  state_t          w_state_nxt;
  alu_op_t         w_op;
  alu_op_t         r_op;
  logic            w_accept;
  logic            w_dbz;
  logic            w_md_start;
  logic            w_md_done;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_single;
  logic [XLEN-1:0] w_md_hi;
  logic [XLEN-1:0] w_md_lo;
  logic [XLEN-1:0] w_md_res;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_dbz;

  assign w_op       = alu_op_t'(alu_op);
  assign w_shamt    = b[SHW-1:0];
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_dbz      = is_div(w_op) && (b == '0);
  assign w_md_start = w_accept && is_multicycle(w_op) && !w_dbz;
  assign w_md_res   = ((r_op == ALU_MULHU) || (r_op == ALU_REMU)) ? w_md_hi : w_md_lo;

  // DIVU/REMU only take this path when b == 0; MUL/MULHU never do.
  always_comb begin
    w_single = '0;
    case (w_op)
      ALU_ADD:  w_single = a + b;
      ALU_SUB:  w_single = a - b;
      ALU_AND:  w_single = a & b;
      ALU_OR:   w_single = a | b;
      ALU_XOR:  w_single = a ^ b;
      ALU_SLL:  w_single = a << w_shamt;
      ALU_SRL:  w_single = a >> w_shamt;
      ALU_SRA:  w_single = $unsigned($signed(a) >>> w_shamt);
      ALU_SLT:  w_single = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: w_single = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_DIVU: w_single = '1;
      ALU_REMU: w_single = a;
      default:  w_single = '0;
    endcase
  end

  alu_seq_muldiv #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_md_start),
    .div   (is_div(w_op)),
    .a     (a),
    .b     (b),
    .done  (w_md_done),
    .hi    (w_md_hi),
    .lo    (w_md_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = w_md_start ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_md_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= ALU_ADD;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_op <= w_op;
      if (!w_md_start) begin
        r_result <= w_single;
        r_zero   <= (w_single == '0);
        r_dbz    <= w_dbz;
      end
    end else if ((r_state == ST_BUSY) && w_md_done) begin
      r_result <= w_md_res;
      r_zero   <= (w_md_res == '0);
      r_dbz    <= 1'b0;
    end
  end

  assign result      = r_result;
  assign zero        = r_zero;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, handshaked successor to the processor's single-cycle ALU. It executes single-cycle integer ops in one registered cycle and unsigned multiply/divide iteratively over XLEN cycles. A valid/ready interface lets the Processor stall on long ops. It sits between the register-read stage (rs1_value/rs2_value) and writeback.

## Interface
- XLEN, 32: operand/result width (≥ 8, power of two)
- CNT_W, $clog2(XLEN)+1: iteration counter width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- alu_op  in  4  operation code (alu_pkg::alu_op_t)
- a  in  XLEN  operand 1 (rs1_value)
- b  in  XLEN  operand 2 (rs2_value)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  result == 0, registered with result
- div_by_zero  out  1  DIVU/REMU issued with b == 0, registered with result

## Operation
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, MUL 10 (low XLEN bits), MULHU 11 (high XLEN bits, unsigned), DIVU 12, REMU 13. Codes 14–15 return 0 with latency 1.
- Shift amount is b[$clog2(XLEN)-1:0]. SLT/SLTU return 1 or 0, zero-extended. All arithmetic wraps modulo 2^XLEN.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On in_valid, operands and op are captured.
  - Single-cycle op or division by zero: IDLE → DONE.
  - MUL/MULHU/DIVU/REMU: IDLE → BUSY, counter loaded with XLEN.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. Counter decrements. When the counter reaches 0, BUSY → DONE.
  - DONE: out_valid = 1. result, zero and div_by_zero are held stable. On out_ready, DONE → IDLE.
- Division by zero follows RISC-V: DIVU gives all-ones, REMU gives a. div_by_zero = 1 and the iteration is skipped.
- in_ready = 0 in BUSY and DONE. Requests are not queued.
- in_valid while busy is ignored. The requester holds it per valid/ready rules.

## Timing
- Reset (asynchronous, any state including BUSY): state = IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 0, div_by_zero = 0, counter = 0. An in-flight op is discarded.
- Single-cycle op accepted at edge t: out_valid high from edge t+1.
- MUL/MULHU/DIVU/REMU accepted at edge t: out_valid high from edge t+XLEN+1.
- Divide by zero accepted at edge t: out_valid high from edge t+1.
- out_valid & out_ready at edge u: out_valid low and in_ready high from u+1. Throughput is therefore at most one op per 2 cycles.
- Backpressure: out_ready may stay low indefinitely. The result stays stable.
- in_ready and out_valid are never high in the same cycle.

## Structure
- Package alu_pkg holds:
  - alu_op_t enum (4 bit, codes above)
  - state_t enum (IDLE, BUSY, DONE)
  - an is_multicycle(op) function
- Sub-module alu_seq_muldiv, parametrised by XLEN:
  - iterative multiplier/divider with start, done, op select, and hi/lo outputs
  - holds the 2·XLEN accumulator and the counter
- The top level holds the FSM, the combinational single-cycle datapath and the output registers.

## Test plan
- Reset then ADD a=1, b=2, out_ready=1 → out_valid at cycle 1, result=3, zero=0. Then SUB 5−5 → result=0, zero=1.
- SRA a=0x80000000, b=4 → 0xF8000000. SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0.
- MUL 6×4 → result=24 with out_valid exactly 33 cycles after accept. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIVU 100/7 → 14 and REMU 100/7 → 2, each after 33 cycles. DIVU 9/0 → 0xFFFFFFFF with div_by_zero=1 after 1 cycle. REMU 9/0 → 9.
- Hold out_ready=0 for 10 cycles after a MUL completes → result stable, in_ready=0, a new in_valid is ignored. Raise out_ready → in_ready the next cycle.
- Assert rst_n=0 mid-DIVU (cycle 10 of 32) → out_valid=0, result=0, in_ready=1 immediately. A following ADD 1+1 → 2.
- Repeat the ADD, MUL and DIVU cases with XLEN=8 and XLEN=64 → latency XLEN+1 and correct wraparound (XLEN=8: ADD 0xFF+1 → 0x00, zero=1).
